// File: rtl/gbuff_loader_if.sv
// rtl/gbuff_loader_if.sv - host stream, global-buffer write and TPU control bundle for gbuff_loader
interface gbuff_loader_if #(
  parameter int WORD_SIZE  = 32,
  parameter int INDEX_SIZE = 32,
  parameter int CNT_W      = 16
);
  logic                  go;
  logic [CNT_W-1:0]      len_a;
  logic [CNT_W-1:0]      len_b;
  logic [3:0]            m;
  logic [3:0]            n;
  logic [3:0]            k;
  logic                  s_valid;
  logic [WORD_SIZE-1:0]  s_data;
  logic                  s_ready;
  logic                  wr_en_a;
  logic                  wr_en_b;
  logic [INDEX_SIZE-1:0] index_a;
  logic [INDEX_SIZE-1:0] index_b;
  logic [WORD_SIZE-1:0]  data_a;
  logic [WORD_SIZE-1:0]  data_b;
  logic                  tpu_start;
  logic [3:0]            tpu_m;
  logic [3:0]            tpu_n;
  logic [3:0]            tpu_k;
  logic                  tpu_done;
  logic                  busy;
  logic                  job_done;

  modport master (
    output go, len_a, len_b, m, n, k, s_valid, s_data, tpu_done,
    input  s_ready, wr_en_a, wr_en_b, index_a, index_b, data_a, data_b,
           tpu_start, tpu_m, tpu_n, tpu_k, busy, job_done
  );

  modport slave (
    input  go, len_a, len_b, m, n, k, s_valid, s_data, tpu_done,
    output s_ready, wr_en_a, wr_en_b, index_a, index_b, data_a, data_b,
           tpu_start, tpu_m, tpu_n, tpu_k, busy, job_done
  );
endinterface

// File: rtl/gbuff_loader.sv
// rtl/gbuff_loader.sv - streams A then B words into the global buffers, then starts and waits on the TPU
module gbuff_loader #(
  parameter int WORD_SIZE  = 32,
  parameter int INDEX_SIZE = 32,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  gbuff_loader_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, FIN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_a_q, len_a_d;
  logic [CNT_W-1:0]      len_b_q, len_b_d;
  logic                  s_ready_q, s_ready_d;
  logic                  wr_en_a_q, wr_en_a_d;
  logic                  wr_en_b_q, wr_en_b_d;
  logic [INDEX_SIZE-1:0] index_a_q, index_a_d;
  logic [INDEX_SIZE-1:0] index_b_q, index_b_d;
  logic [WORD_SIZE-1:0]  data_a_q, data_a_d;
  logic [WORD_SIZE-1:0]  data_b_q, data_b_d;
  logic                  tpu_start_q, tpu_start_d;
  logic [3:0]            tpu_m_q, tpu_m_d;
  logic [3:0]            tpu_n_q, tpu_n_d;
  logic [3:0]            tpu_k_q, tpu_k_d;
  logic                  busy_q, busy_d;
  logic                  job_done_q, job_done_d;
  logic                  xfer;
  logic [CNT_W-1:0]      cnt_inc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_a_d     = len_a_q;
    len_b_d     = len_b_q;
    wr_en_a_d   = 1'b0;
    wr_en_b_d   = 1'b0;
    index_a_d   = index_a_q;
    index_b_d   = index_b_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    tpu_start_d = 1'b0;
    tpu_m_d     = tpu_m_q;
    tpu_n_d     = tpu_n_q;
    tpu_k_d     = tpu_k_q;
    xfer        = bus.s_valid && s_ready_q;
    cnt_inc     = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          len_a_d = bus.len_a;
          len_b_d = bus.len_b;
          tpu_m_d = bus.m;
          tpu_n_d = bus.n;
          tpu_k_d = bus.k;
          cnt_d   = '0;
          if (bus.len_a != '0)      state_d = LOAD_A;
          else if (bus.len_b != '0) state_d = LOAD_B;
          else                      state_d = START;
        end
      end
      LOAD_A: begin
        if (xfer) begin
          wr_en_a_d = 1'b1;
          index_a_d = INDEX_SIZE'(cnt_q);
          data_a_d  = bus.s_data;
          cnt_d     = cnt_inc;
          // Last A word: counter restarts for B, or skip straight to START.
          if (cnt_inc == len_a_q) begin
            cnt_d   = '0;
            state_d = (len_b_q != '0) ? LOAD_B : START;
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          wr_en_b_d = 1'b1;
          index_b_d = INDEX_SIZE'(cnt_q);
          data_b_d  = bus.s_data;
          cnt_d     = cnt_inc;
          if (cnt_inc == len_b_q) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
      end
      START: begin
        // Pulse lands one cycle after the START cycle, i.e. after the last write is visible.
        tpu_start_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (bus.tpu_done) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
    busy_d     = (state_d != IDLE);
    job_done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_a_q     <= '0;
      len_b_q     <= '0;
      s_ready_q   <= 1'b0;
      wr_en_a_q   <= 1'b0;
      wr_en_b_q   <= 1'b0;
      index_a_q   <= '0;
      index_b_q   <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      tpu_start_q <= 1'b0;
      tpu_m_q     <= '0;
      tpu_n_q     <= '0;
      tpu_k_q     <= '0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_a_q     <= len_a_d;
      len_b_q     <= len_b_d;
      s_ready_q   <= s_ready_d;
      wr_en_a_q   <= wr_en_a_d;
      wr_en_b_q   <= wr_en_b_d;
      index_a_q   <= index_a_d;
      index_b_q   <= index_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      tpu_start_q <= tpu_start_d;
      tpu_m_q     <= tpu_m_d;
      tpu_n_q     <= tpu_n_d;
      tpu_k_q     <= tpu_k_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.wr_en_a   = wr_en_a_q;
  assign bus.wr_en_b   = wr_en_b_q;
  assign bus.index_a   = index_a_q;
  assign bus.index_b   = index_b_q;
  assign bus.data_a    = data_a_q;
  assign bus.data_b    = data_b_q;
  assign bus.tpu_start = tpu_start_q;
  assign bus.tpu_m     = tpu_m_q;
  assign bus.tpu_n     = tpu_n_q;
  assign bus.tpu_k     = tpu_k_q;
  assign bus.busy      = busy_q;
  assign bus.job_done  = job_done_q;
endmodule

// File: tb/tb_gbuff_loader.sv
// tb/tb_gbuff_loader.sv - randomized job-level bench for gbuff_loader against expected write lists
module tb_gbuff_loader;
  localparam int WS = 32;
  localparam int IS = 32;
  localparam int CW = 16;
  localparam logic [63:0] ZERO = 64'd0;
  localparam logic [63:0] ONE  = 64'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gbuff_loader_if #(.WORD_SIZE(WS), .INDEX_SIZE(IS), .CNT_W(CW)) bus();

  gbuff_loader #(.WORD_SIZE(WS), .INDEX_SIZE(IS), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.s_ready, bus.wr_en_a, bus.wr_en_b, bus.tpu_start, bus.busy,
                            bus.job_done, bus.tpu_m, bus.tpu_n, bus.tpu_k}), ZERO);
    chk({tag, "_index"}, {bus.index_a, bus.index_b}, ZERO);
    chk({tag, "_data"}, {bus.data_a, bus.data_b}, ZERO);
  endtask

  // One job: expected writes are the word lists in order; start follows the last write by one
  // cycle (or go by two for an empty job); job_done follows the accepted tpu_done pulse by one.
  task automatic run_job(input int la, input int lb, input logic [3:0] jm, input logic [3:0] jn,
                         input logic [3:0] jk, input bit stall, input bit hold_done, input int abort_n);
    logic [31:0] send_q[$];
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    logic [31:0] w;
    logic [63:0] e;
    int go_cyc, last_wr, pulse_at, done_cyc, starts, sent, writes_a, writes_b;
    bit seen_start;
    for (int i = 0; i < la; i++) begin
      w = $urandom;
      send_q.push_back(w);
      exp_a.push_back({32'(i), w});
    end
    for (int i = 0; i < lb; i++) begin
      w = $urandom;
      send_q.push_back(w);
      exp_b.push_back({32'(i), w});
    end
    chk("idle_before_go", 64'(bus.busy), ZERO);
    bus.go = 1'b1;
    bus.len_a = CW'(la);
    bus.len_b = CW'(lb);
    bus.m = jm;
    bus.n = jn;
    bus.k = jk;
    bus.s_valid = 1'b0;
    go_cyc = cyc;
    last_wr = -10; pulse_at = -10; done_cyc = -10;
    starts = 0; sent = 0; writes_a = 0; writes_b = 0; seen_start = 1'b0;
    forever begin
      tick();
      bus.go = 1'b0;
      if (cyc - go_cyc > 2000) begin
        chk("job_timeout_cycles", 64'(cyc - go_cyc), ZERO);
        break;
      end
      chk("wr_exclusive", 64'(bus.wr_en_a & bus.wr_en_b), ZERO);
      if (bus.wr_en_a) begin
        writes_a++;
        last_wr = cyc;
        if (exp_a.size() > 0) begin
          e = exp_a.pop_front();
          chk("wr_a_index_data", {bus.index_a, bus.data_a}, e);
        end
      end
      if (bus.wr_en_b) begin
        writes_b++;
        last_wr = cyc;
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          chk("wr_b_index_data", {bus.index_b, bus.data_b}, e);
        end
      end
      if (bus.tpu_start) begin
        starts++;
        if (!seen_start) begin
          seen_start = 1'b1;
          chk("start_cycle", 64'(cyc), 64'((la + lb == 0) ? go_cyc + 2 : last_wr + 1));
          chk("tpu_dims", 64'({bus.tpu_m, bus.tpu_n, bus.tpu_k}), 64'({jm, jn, jk}));
          pulse_at = cyc + int'($urandom_range(1, 6));
        end
      end
      if (seen_start && cyc == pulse_at + 1) begin
        chk("job_done_pulse", 64'(bus.job_done), ONE);
        chk("dims_held", 64'({bus.tpu_m, bus.tpu_n, bus.tpu_k}), 64'({jm, jn, jk}));
        done_cyc = cyc;
      end else begin
        chk("job_done_quiet", 64'(bus.job_done), ZERO);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", 64'(bus.busy), ZERO);
        chk("start_count", 64'(starts), ONE);
        chk("wr_a_total", 64'(writes_a), 64'(la));
        chk("wr_b_total", 64'(writes_b), 64'(lb));
        break;
      end
      chk("busy_during_job", 64'(bus.busy), ONE);
      if (abort_n >= 0 && writes_a + writes_b == abort_n) begin
        rst = 1'b1;
        bus.s_valid = 1'b0;
        break;
      end
      if (bus.s_ready && send_q.size() > 0 && !(abort_n >= 0 && sent >= abort_n) &&
          (!stall || $urandom_range(0, 3) != 0)) begin
        bus.s_valid = 1'b1;
        bus.s_data = send_q.pop_front();
        sent++;
      end else if (bus.s_ready) begin
        bus.s_valid = 1'b0;
        bus.s_data = $urandom;
      end else begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data = $urandom;
      end
      if (!seen_start) bus.tpu_done = hold_done ? 1'b1 : 1'($urandom_range(0, 1));
      else bus.tpu_done = (cyc == pulse_at);
      if (done_cyc < 0 && $urandom_range(0, 7) == 0) begin
        bus.go = 1'b1;
        bus.len_a = CW'($urandom_range(1, 9));
        bus.len_b = CW'($urandom_range(1, 9));
        bus.m = 4'($urandom);
        bus.n = 4'($urandom);
        bus.k = 4'($urandom);
      end
    end
    bus.go = 1'b0;
    bus.s_valid = 1'b0;
    bus.tpu_done = 1'b0;
  endtask

  initial begin
    bus.go = 1'b0; bus.len_a = '0; bus.len_b = '0;
    bus.m = '0; bus.n = '0; bus.k = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.tpu_done = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("idle_after_reset");

    run_job(4, 4, 4'd4, 4'd4, 4'd4, 1'b0, 1'b0, -1);
    run_job(4, 4, 4'd4, 4'd4, 4'd4, 1'b1, 1'b0, -1);
    run_job(0, 0, 4'd3, 4'd5, 4'd7, 1'b0, 1'b0, -1);
    run_job(4, 4, 4'd2, 4'd9, 4'd1, 1'b1, 1'b1, -1);
    run_job(0, 3, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, -1);
    run_job(3, 0, 4'd6, 4'd6, 4'd6, 1'b1, 1'b1, -1);

    run_job(4, 4, 4'd8, 4'd8, 4'd8, 1'b0, 1'b0, 2);
    tick();
    chk_zero("abort");
    rst = 1'b0;
    bus.tpu_done = 1'b0;
    repeat (4) begin
      tick();
      chk("abort_no_restart", 64'({bus.busy, bus.wr_en_a, bus.wr_en_b, bus.tpu_start}), ZERO);
    end
    run_job(2, 0, 4'd5, 4'd4, 4'd3, 1'b0, 1'b0, -1);

    for (int j = 0; j < 25; j++) begin
      run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 4'($urandom), 4'($urandom),
              4'($urandom), 1'b1, 1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gbuff_loader.md
GBUFF_LOADER -- requirements
Module: gbuff_loader

Interface
REQ-001 Parameter WORD_SIZE, default 32, global-buffer word width in bits (four 8-bit operands per word).
REQ-002 Parameter INDEX_SIZE, default 32, global-buffer index width in bits.
REQ-003 Parameter CNT_W, default 16, width of the word-count inputs.
REQ-004 The block SHALL have one clock and one reset, and reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 go  input  1  one-cycle request to begin a load-and-run job.
REQ-008 len_a, len_b  input  CNT_W each  word counts for matrices A and B; sampled on an accepted go.
REQ-009 m, n, k  input  4 each  matrix dimensions; sampled on an accepted go.
REQ-010 s_valid  input  1  host stream word valid.
REQ-011 s_data  input  WORD_SIZE  host stream word; all A words are sent first, then all B words.
REQ-012 s_ready  output  1  loader accepts s_data this cycle.
REQ-013 wr_en_a, wr_en_b  output  1 each  write enables to GBUFF_A and GBUFF_B.
REQ-014 index_a, index_b  output  INDEX_SIZE each  write index to GBUFF_A and GBUFF_B.
REQ-015 data_a, data_b  output  WORD_SIZE each  write data to GBUFF_A and GBUFF_B.
REQ-016 tpu_start  output  1  start pulse to the TPU top.
REQ-017 tpu_m, tpu_n, tpu_k  output  4 each  registered dimensions presented to the TPU top.
REQ-018 tpu_done  input  1  done level from the TPU top.
REQ-019 busy  output  1  high from an accepted go until the job ends; integration muxes the buffer ports to the loader while busy is high and the state is LOAD_A or LOAD_B.
REQ-020 job_done  output  1  one-cycle pulse when the TPU reports completion.

Function
REQ-021 FSM states SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT, FIN.
REQ-022 IDLE with go=1: latch len_a, len_b, m, n, k and clear the word counter. If len_a≠0, go to LOAD_A; else if len_b≠0, go to LOAD_B; else go to START.
REQ-023 go SHALL be ignored in every state other than IDLE.
REQ-024 s_ready SHALL be 1 only in LOAD_A and LOAD_B; a word transfers on each cycle with s_valid=1 and s_ready=1.
REQ-025 On a transfer in LOAD_A, the next cycle SHALL show wr_en_a=1, index_a=counter value and data_a=s_data, giving one-cycle registered latency; wr_en_b SHALL be 0.
REQ-026 LOAD_B SHALL behave the same way on the B ports, with the counter restarted at 0.
REQ-027 The counter SHALL increment only on a transfer; stalls (s_valid=0) SHALL hold the index and deassert the write enable.
REQ-028 The transfer carrying word len_a-1 SHALL move the FSM to LOAD_B, or to START if len_b=0.
REQ-029 The transfer carrying word len_b-1 SHALL move the FSM to START.
REQ-030 wr_en_a and wr_en_b SHALL never be 1 in the same cycle.
REQ-031 START SHALL last exactly one cycle with tpu_start=1, and SHALL be entered only after the final buffer write has been issued; it then goes to WAIT.
REQ-032 tpu_m, tpu_n, tpu_k SHALL hold the latched values from go until the next accepted go.
REQ-033 WAIT on tpu_done=1 SHALL go to FIN; tpu_done SHALL be ignored outside WAIT.
REQ-034 FIN SHALL assert job_done=1 for one cycle and then return to IDLE.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 Index width rule: the counter SHALL be zero-extended to INDEX_SIZE; lengths above 2^INDEX_SIZE are out of scope.

Reset
REQ-037 While rst=1, state SHALL be IDLE and the counter and latched lengths SHALL be 0.
REQ-038 While rst=1, all outputs SHALL be 0, including s_ready, wr_en_a, wr_en_b, index_a, index_b, data_a, data_b, tpu_start, tpu_m, tpu_n, tpu_k, busy and job_done.
REQ-039 rst asserted mid-job SHALL abort the job on the next edge with no further write or start, and SHALL not restart it.

Verification
REQ-040 Scenario 1: go with len_a=4, len_b=4, m=n=k=4, and 8 back-to-back words 0x0..0x7 -> wr_en_a at indices 0..3 with data 0..3, then wr_en_b at indices 0..3 with data 4..7, tpu_start one cycle after the last write, tpu_m=tpu_n=tpu_k=4.
REQ-041 Scenario 2: same job with s_valid toggled 1,0,1,0 -> writes occur only for accepted words, indices stay contiguous, and there are still 8 writes total.
REQ-042 Scenario 3: go with len_a=0, len_b=0 -> no writes, tpu_start asserted 2 cycles after go (IDLE→START→tpu_start), busy high until job_done.
REQ-043 Scenario 4: tpu_done held 1 during LOAD_A, then pulsed 5 cycles after tpu_start -> ignored during LOAD_A, job_done exactly one cycle after the pulse, and busy falls the cycle after that.
REQ-044 Scenario 5: second go while busy -> ignored, with no length re-latch and no second tpu_start.
REQ-045 Scenario 6: rst=1 after 2 of 4 A words -> all outputs are 0 next cycle, state is IDLE, and a later go with len_a=2 writes from index 0.
